// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with a saturating match counter.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous reset, active-high
//   en        - sample enable; x consumed only when en=1
//   x         - serial input bit
//   clr_cnt   - synchronous clear of match_cnt
//   y         - match flag (state == S_PAT_W)
//   state_o   - current state index
//   match_cnt - saturating match count
//   cnt_sat   - match_cnt is all-ones
module moore_seq_detector #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8,
  localparam int            SW      = $clog2(PAT_W+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             y,
  output logic [SW-1:0]    state_o,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int NS = 2**SW;
  localparam logic [SW-1:0] S_FULL =
    SW'(PAT_W);

  // Longest pattern prefix that is a suffix
  // of (first k pattern bits, then b).
  // seq[0] is the newest bit.
  function automatic int calc(
    input int k,
    input bit b
  );
    logic [16:0] seq;
    int best;
    bit ok;
    seq = '0;
    seq[0] = b;
    for (int i = 1; i <= PAT_W; i++) begin
      if (i <= k)
        seq[i] = PATTERN[PAT_W-k+i-1];
    end
    best = 0;
    for (int j = 1; j <= PAT_W; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
          if (i < j) begin
            if (seq[i] != PATTERN[PAT_W-j+i])
              ok = 1'b0;
          end
        end
        if (ok)
          best = j;
      end
    end
    return best;
  endfunction

  logic [SW-1:0] tbl0 [NS];
  logic [SW-1:0] tbl1 [NS];

  // Full state either keeps its history
  // (overlap) or behaves like S0.
  for (genvar k = 0; k < NS; k++) begin : g_tbl
    if (k <= PAT_W) begin : g_ok
      localparam int K =
        (k == PAT_W) ?
        (OVERLAP ? PAT_W : 0) : k;
      localparam logic [SW-1:0] N0 =
        SW'(calc(K, 1'b0));
      localparam logic [SW-1:0] N1 =
        SW'(calc(K, 1'b1));
      assign tbl0[k] = N0;
      assign tbl1[k] = N1;
    end else begin : g_ill
      assign tbl0[k] = '0;
      assign tbl1[k] = '0;
    end
  end

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic          ill;
  logic          hit;

  always_ff @(posedge clk) begin
    if (rst)
      state <= '0;
    else
      state <= state_nxt;
  end

  assign ill = (state > S_FULL);

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      !en:
        state_nxt = state;
      en && ill:
        state_nxt = '0;
      en && !ill && x:
        state_nxt = tbl1[state];
      en && !ill && !x:
        state_nxt = tbl0[state];
      default:
        state_nxt = '0;
    endcase
  end

  always_comb begin
    y       = (state == S_FULL);
    state_o = state;
    cnt_sat = &match_cnt;
  end

  // Every enabled edge landing in S_FULL
  // is a new match, including self-loops.
  assign hit = en && (state_nxt == S_FULL);

  always_ff @(posedge clk) begin
    if (rst)
      match_cnt <= '0;
    else if (clr_cnt)
      match_cnt <= '0;
    else if (hit && !cnt_sat)
      match_cnt <= match_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector.
// Three instances: 1011 overlap, 1011 no-overlap, 11 with 2-bit count.
module tb_moore_seq_detector;

  logic clk = 1'b0;
  logic rst, en, x, clr_cnt;

  logic       ya, yb, yc;
  logic [2:0] sa, sb;
  logic [1:0] sc;
  logic [7:0] ca, cb;
  logic [1:0] cc;
  logic       ta, tb, tc;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  moore_seq_detector u_a (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .clr_cnt(clr_cnt), .y(ya), .state_o(sa),
    .match_cnt(ca), .cnt_sat(ta)
  );

  moore_seq_detector #(
    .OVERLAP(1'b0)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .clr_cnt(clr_cnt), .y(yb), .state_o(sb),
    .match_cnt(cb), .cnt_sat(tb)
  );

  moore_seq_detector #(
    .PAT_W(2), .PATTERN(2'b11),
    .OVERLAP(1'b1), .CNT_W(2)
  ) u_c (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .clr_cnt(clr_cnt), .y(yc), .state_o(sc),
    .match_cnt(cc), .cnt_sat(tc)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    x   = 1'b0;
    clr_cnt = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int xs1 [7] = '{1,0,1,1,0,1,1};
  int sa1 [7] = '{1,2,3,4,2,3,4};
  int sb1 [7] = '{1,2,3,4,0,1,1};
  int xs2 [6] = '{1,0,1,0,1,1};
  int sa2 [6] = '{1,2,3,2,3,4};
  int cc4 [6] = '{0,1,2,3,3,3};

  initial begin
    rst = 1'b1;
    en = 1'b0;
    x = 1'b0;
    clr_cnt = 1'b0;

    // reset state
    do_reset();
    chk("rst_sa", 32'(sa), 0);
    chk("rst_ya", 32'(ya), 0);
    chk("rst_ca", 32'(ca), 0);
    chk("rst_ta", 32'(ta), 0);
    chk("rst_sc", 32'(sc), 0);

    // overlap vs non-overlap on 1011011
    for (int i = 0; i < 7; i++) begin
      x = xs1[i][0];
      tick();
      chk($sformatf("t1_sa%0d", i),
          32'(sa), 32'(sa1[i]));
      chk($sformatf("t1_ya%0d", i),
          32'(ya), (sa1[i] == 4) ? 1 : 0);
      chk($sformatf("t1_sb%0d", i),
          32'(sb), 32'(sb1[i]));
      chk($sformatf("t1_yb%0d", i),
          32'(yb), (sb1[i] == 4) ? 1 : 0);
    end
    chk("t1_ca", 32'(ca), 2);
    chk("t1_cb", 32'(cb), 1);

    // failure fallback 101011
    do_reset();
    for (int i = 0; i < 6; i++) begin
      x = xs2[i][0];
      tick();
      chk($sformatf("t2_sa%0d", i),
          32'(sa), 32'(sa2[i]));
    end
    chk("t2_ya", 32'(ya), 1);
    chk("t2_ca", 32'(ca), 1);

    // en gating, then reset mid-pattern
    do_reset();
    x = 1'b1; tick();
    x = 1'b0; tick();
    x = 1'b1; tick();
    chk("t3_s3", 32'(sa), 3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x = i[0];
      tick();
      chk($sformatf("t3_hold%0d", i),
          32'(sa), 3);
      chk($sformatf("t3_y0_%0d", i),
          32'(ya), 0);
    end
    en = 1'b1;
    x = 1'b1;
    tick();
    chk("t3_y1", 32'(ya), 1);
    chk("t3_c1", 32'(ca), 1);
    en = 1'b0;
    x = 1'b0;
    tick();
    chk("t3_yhold", 32'(ya), 1);
    chk("t3_chold", 32'(ca), 1);
    en = 1'b1;
    x = 1'b1; tick();
    chk("t3_ov1", 32'(sa), 1);
    x = 1'b0; tick();
    chk("t3_ov2", 32'(sa), 2);
    rst = 1'b1;
    x = 1'b1;
    tick();
    rst = 1'b0;
    chk("t3_rs", 32'(sa), 0);
    chk("t3_rc", 32'(ca), 0);
    chk("t3_ry", 32'(ya), 0);
    x = 1'b1; tick();
    chk("t3_after", 32'(sa), 1);

    // saturation and clear on 11, CNT_W=2
    do_reset();
    x = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t4_cc%0d", i),
          32'(cc), 32'(cc4[i]));
      chk($sformatf("t4_tc%0d", i),
          32'(tc), (cc4[i] == 3) ? 1 : 0);
    end
    chk("t4_yc", 32'(yc), 1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("t4_clr", 32'(cc), 0);
    chk("t4_clr_t", 32'(tc), 0);
    chk("t4_clr_y", 32'(yc), 1);
    chk("t4_clr_s", 32'(sc), 2);
    tick();
    chk("t4_post", 32'(cc), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
